adder_result_checker: RTL and testbench

- Self-checking response monitor for the 8-bit adder family (ripple, carry-increment and similar).
- Samples one operand/result vector per valid cycle: A, B, Cin from the stimulus side and S, Cout from the adder under test.
- Computes the golden A+B+Cin, compares it with the adder output, and keeps vector and error counts.
- Reports pass/fail at the end of a run; it is the receiving end of the adder stimulus stream.

---
 rtl/adder_result_checker.sv | 151 +++++++++++++++
 tb/tb_adder_result_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Response monitor for the W-bit adder family: checks {Cout,S} against A+B+Cin and counts vectors/errors per run.
// Optional first-failure capture of A/B/Cin/S is built when ADDCHK_FIRST_FAIL_CAPTURE_EN is defined.
module adder_result_checker #(
    parameter int W           = 8,
    parameter int NUM_VECTORS = 256,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             Cin,
    input  logic [W-1:0]     S,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [W-1:0]     fail_A,
    output logic [W-1:0]     fail_B,
    output logic             fail_Cin,
    output logic [W-1:0]     fail_S
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(NUM_VECTORS);
    localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ERR_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] vec_count_q, vec_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             mismatch_q, mismatch_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [W:0]       expected;
    logic             miss;
    logic             sample;

    always_comb begin
        expected    = {1'b0, A} + {1'b0, B} + (W+1)'(Cin);
        miss        = ({Cout, S} != expected);
        // a start pulse takes priority, so a vector presented with it is dropped
        sample      = (state_q == RUN) && vec_valid && !start;
        state_d     = state_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        mismatch_d  = 1'b0;
        if (start) begin
            state_d     = RUN;
            vec_count_d = '0;
            err_count_d = '0;
        end else if (sample) begin
            vec_count_d = vec_count_q + ONE;
            if (miss) begin
                mismatch_d = 1'b1;
                if (err_count_q != ERR_MAX)
                    err_count_d = err_count_q + ONE;
            end
            if (vec_count_d == LAST)
                state_d = DONE;
        end
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = (state_d == DONE) && (err_count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            vec_count_q <= '0;
            err_count_q <= '0;
            mismatch_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            mismatch_q  <= mismatch_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign mismatch  = mismatch_q;
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;

`ifdef ADDCHK_FIRST_FAIL_CAPTURE_EN
    logic [W-1:0] fail_a_q, fail_a_d;
    logic [W-1:0] fail_b_q, fail_b_d;
    logic         fail_cin_q, fail_cin_d;
    logic [W-1:0] fail_s_q, fail_s_d;

    // only the first miss of a run is kept: err_count is still zero before that edge
    always_comb begin
        fail_a_d   = fail_a_q;
        fail_b_d   = fail_b_q;
        fail_cin_d = fail_cin_q;
        fail_s_d   = fail_s_q;
        if (start) begin
            fail_a_d   = '0;
            fail_b_d   = '0;
            fail_cin_d = 1'b0;
            fail_s_d   = '0;
        end else if (sample && miss && (err_count_q == '0)) begin
            fail_a_d   = A;
            fail_b_d   = B;
            fail_cin_d = Cin;
            fail_s_d   = S;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_cin_q <= 1'b0;
            fail_s_q   <= '0;
        end else begin
            fail_a_q   <= fail_a_d;
            fail_b_q   <= fail_b_d;
            fail_cin_q <= fail_cin_d;
            fail_s_q   <= fail_s_d;
        end
    end

    assign fail_A   = fail_a_q;
    assign fail_B   = fail_b_q;
    assign fail_Cin = fail_cin_q;
    assign fail_S   = fail_s_q;
`else
    assign fail_A   = '0;
    assign fail_B   = '0;
    assign fail_Cin = 1'b0;
    assign fail_S   = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Bench for adder_result_checker: directed test-plan scenarios plus randomized runs against a list-based model.
module tb_adder_result_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       vld = 1'b0;
    logic [7:0] a = '0, b = '0, s = '0;
    logic       cin = 1'b0, cout = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // d1/d3/d4: NUM_VECTORS 1/3/4; ds: CNT_W=4 NUM=15; dt: CNT_W=3 NUM=7
    logic        d1_busy, d1_done, d1_pass, d1_mis, d1_fcin;
    logic [15:0] d1_vec, d1_err;
    logic [7:0]  d1_fa, d1_fb, d1_fs;
    logic        d3_busy, d3_done, d3_pass, d3_mis, d3_fcin;
    logic [15:0] d3_vec, d3_err;
    logic [7:0]  d3_fa, d3_fb, d3_fs;
    logic        d4_busy, d4_done, d4_pass, d4_mis, d4_fcin;
    logic [15:0] d4_vec, d4_err;
    logic [7:0]  d4_fa, d4_fb, d4_fs;
    logic        ds_busy, ds_done, ds_pass, ds_mis, ds_fcin;
    logic [3:0]  ds_vec, ds_err;
    logic [7:0]  ds_fa, ds_fb, ds_fs;
    logic        dt_busy, dt_done, dt_pass, dt_mis, dt_fcin;
    logic [2:0]  dt_vec, dt_err;
    logic [7:0]  dt_fa, dt_fb, dt_fs;

    adder_result_checker #(.W(8), .NUM_VECTORS(1), .CNT_W(16)) d1 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vld), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
        .busy(d1_busy), .done(d1_done), .pass(d1_pass), .mismatch(d1_mis), .vec_count(d1_vec), .err_count(d1_err),
        .fail_A(d1_fa), .fail_B(d1_fb), .fail_Cin(d1_fcin), .fail_S(d1_fs));
    adder_result_checker #(.W(8), .NUM_VECTORS(3), .CNT_W(16)) d3 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vld), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
        .busy(d3_busy), .done(d3_done), .pass(d3_pass), .mismatch(d3_mis), .vec_count(d3_vec), .err_count(d3_err),
        .fail_A(d3_fa), .fail_B(d3_fb), .fail_Cin(d3_fcin), .fail_S(d3_fs));
    adder_result_checker #(.W(8), .NUM_VECTORS(4), .CNT_W(16)) d4 (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vld), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
        .busy(d4_busy), .done(d4_done), .pass(d4_pass), .mismatch(d4_mis), .vec_count(d4_vec), .err_count(d4_err),
        .fail_A(d4_fa), .fail_B(d4_fb), .fail_Cin(d4_fcin), .fail_S(d4_fs));
    adder_result_checker #(.W(8), .NUM_VECTORS(15), .CNT_W(4)) ds (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vld), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
        .busy(ds_busy), .done(ds_done), .pass(ds_pass), .mismatch(ds_mis), .vec_count(ds_vec), .err_count(ds_err),
        .fail_A(ds_fa), .fail_B(ds_fb), .fail_Cin(ds_fcin), .fail_S(ds_fs));
    adder_result_checker #(.W(8), .NUM_VECTORS(7), .CNT_W(3)) dt (
        .clk(clk), .rst(rst), .start(start), .vec_valid(vld), .A(a), .B(b), .Cin(cin), .S(s), .Cout(cout),
        .busy(dt_busy), .done(dt_done), .pass(dt_pass), .mismatch(dt_mis), .vec_count(dt_vec), .err_count(dt_err),
        .fail_A(dt_fa), .fail_B(dt_fb), .fail_Cin(dt_fcin), .fail_S(dt_fs));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // start pulse carries a failing vector that must be ignored
    task automatic do_start();
        start = 1'b1; vld = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0; s = 8'h77; cout = 1'b1;
        tick();
        start = 1'b0; vld = 1'b0;
    endtask

    task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                         input logic [7:0] vs, input logic vco);
        vld = 1'b1; a = va; b = vb; cin = vc; s = vs; cout = vco;
        tick();
        vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++; if ({d4_busy, d4_done, d4_pass, d4_mis} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {d4_busy, d4_done, d4_pass, d4_mis}); end
        n_cmp++; if ({d4_vec, d4_err} !== 32'h0) begin n_bad++; $display("FAIL reset_counts got %h want 0", {d4_vec, d4_err}); end
        n_cmp++; if ({d4_fa, d4_fb, d4_fcin, d4_fs} !== 25'h0) begin n_bad++; $display("FAIL reset_fail_regs got %h want 0", {d4_fa, d4_fb, d4_fcin, d4_fs}); end
        rst = 1'b0;
        tick();
        // valid vectors while idle are ignored
        for (int i = 0; i < 3; i++) apply(8'h01, 8'h02, 1'b0, 8'h09, 1'b0);
        n_cmp++; if (d4_vec !== 16'd0 || d4_busy !== 1'b0) begin n_bad++; $display("FAIL idle_ignore vec=%0d busy=%b want 0 0", d4_vec, d4_busy); end
    endtask

    task automatic test_single();
        do_start();
        apply(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
        n_cmp++; if (d1_vec !== 16'd1 || d1_err !== 16'd0) begin n_bad++; $display("FAIL single_counts vec=%0d err=%0d want 1 0", d1_vec, d1_err); end
        n_cmp++; if ({d1_done, d1_pass, d1_mis, d1_busy} !== 4'b1100) begin n_bad++; $display("FAIL single_flags got %b want 1100", {d1_done, d1_pass, d1_mis, d1_busy}); end
    endtask

    task automatic test_directed4();
        do_start();
        apply(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        apply(8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
        apply(8'h7F, 8'h00, 1'b1, 8'h80, 1'b0);
        n_cmp++; if (d4_done !== 1'b0 || d4_busy !== 1'b1) begin n_bad++; $display("FAIL dir4_early_done done=%b busy=%b want 0 1", d4_done, d4_busy); end
        apply(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1);
        n_cmp++; if (d4_vec !== 16'd4 || d4_err !== 16'd0) begin n_bad++; $display("FAIL dir4_counts vec=%0d err=%0d want 4 0", d4_vec, d4_err); end
        n_cmp++; if (d4_done !== 1'b1 || d4_pass !== 1'b1) begin n_bad++; $display("FAIL dir4_pass done=%b pass=%b want 1 1", d4_done, d4_pass); end
    endtask

    task automatic test_errors();
        logic [7:0] ea;
        logic [7:0] eb;
        logic [7:0] es;
        do_start();
        apply(8'h02, 8'h03, 1'b0, 8'h05, 1'b0);
        n_cmp++; if (d3_mis !== 1'b0) begin n_bad++; $display("FAIL err_mis1 got %b want 0", d3_mis); end
        apply(8'h01, 8'h01, 1'b0, 8'h03, 1'b0);
        n_cmp++; if (d3_mis !== 1'b1) begin n_bad++; $display("FAIL err_mis2 got %b want 1", d3_mis); end
        apply(8'hFF, 8'h01, 1'b0, 8'h00, 1'b0);
        n_cmp++; if (d3_mis !== 1'b1 || d3_done !== 1'b1) begin n_bad++; $display("FAIL err_mis3 mis=%b done=%b want 1 1", d3_mis, d3_done); end
        n_cmp++; if (d3_err !== 16'd2 || d3_pass !== 1'b0) begin n_bad++; $display("FAIL err_count err=%0d pass=%b want 2 0", d3_err, d3_pass); end
`ifdef ADDCHK_FIRST_FAIL_CAPTURE_EN
        ea = 8'h01; eb = 8'h01; es = 8'h03;
`else
        ea = 8'h00; eb = 8'h00; es = 8'h00;
`endif
        n_cmp++; if (d3_fa !== ea || d3_fb !== eb || d3_fcin !== 1'b0 || d3_fs !== es) begin n_bad++; $display("FAIL err_capture got %h %h %b %h want %h %h 0 %h", d3_fa, d3_fb, d3_fcin, d3_fs, ea, eb, es); end
        tick();
        n_cmp++; if (d3_mis !== 1'b0) begin n_bad++; $display("FAIL err_mis_pulse got %b want 0", d3_mis); end
    endtask

    task automatic test_gaps();
        do_start();
        apply(8'h11, 8'h22, 1'b0, 8'h33, 1'b0);
        apply(8'h40, 8'h01, 1'b1, 8'h42, 1'b0);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 8'($urandom);
            tick();
        end
        n_cmp++; if (d4_vec !== 16'd2 || d4_busy !== 1'b1) begin n_bad++; $display("FAIL gap_hold vec=%0d busy=%b want 2 1", d4_vec, d4_busy); end
        apply(8'h05, 8'h05, 1'b0, 8'h0A, 1'b0);
        apply(8'hC0, 8'h40, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) apply(8'h01, 8'h01, 1'b0, 8'h07, 1'b0);
        n_cmp++; if (d4_vec !== 16'd4 || d4_err !== 16'd0 || d4_pass !== 1'b1) begin n_bad++; $display("FAIL done_hold vec=%0d err=%0d pass=%b want 4 0 1", d4_vec, d4_err, d4_pass); end
    endtask

    task automatic test_reset_midrun();
        do_start();
        apply(8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        apply(8'h01, 8'h01, 1'b0, 8'h05, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (d4_vec !== 16'd0 || d4_err !== 16'd0 || d4_busy !== 1'b0) begin n_bad++; $display("FAIL async_reset vec=%0d err=%0d busy=%b want 0 0 0", d4_vec, d4_err, d4_busy); end
        tick(); tick();
        rst = 1'b0;
        tick();
        do_start();
        for (int i = 0; i < 4; i++) apply(8'(i * 3), 8'(i * 5), 1'b0, 8'(i * 8), 1'b0);
        n_cmp++; if (d4_vec !== 16'd4 || d4_pass !== 1'b1) begin n_bad++; $display("FAIL after_reset vec=%0d pass=%b want 4 1", d4_vec, d4_pass); end
    endtask

    task automatic test_saturate();
        do_start();
        for (int i = 0; i < 15; i++) apply(8'(i), 8'h01, 1'b0, 8'(i), 1'b0);
        n_cmp++; if (ds_vec !== 4'd15 || ds_err !== 4'd15 || ds_pass !== 1'b0 || ds_done !== 1'b1) begin n_bad++; $display("FAIL cnt4_all_fail vec=%0d err=%0d pass=%b done=%b want 15 15 0 1", ds_vec, ds_err, ds_pass, ds_done); end
        n_cmp++; if (dt_vec !== 3'd7 || dt_err !== 3'd7 || dt_pass !== 1'b0) begin n_bad++; $display("FAIL cnt3_all_fail vec=%0d err=%0d pass=%b want 7 7 0", dt_vec, dt_err, dt_pass); end
    endtask

    // Model: results depend only on the first NUM valid vectors of the run
    task automatic test_random();
        for (int run = 0; run < 3; run++) begin
            logic [7:0] qa[$];
            logic [7:0] qb[$];
            logic       qc[$];
            logic [7:0] qs[$];
            bit         qm[$];
            int         e4_err, et_err, es_err, first;
            logic [8:0] gold, got;
            do_start();
            while (qm.size() < 10) begin
                bit v, m;
                v = ($urandom_range(0, 3) != 0);
                m = ($urandom_range(0, 3) == 0);
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
                gold = {1'b0, a} + {1'b0, b} + 9'(cin);
                got  = m ? (gold ^ (9'd1 << $urandom_range(0, 8))) : gold;
                {cout, s} = got;
                vld = v;
                if (v) begin qa.push_back(a); qb.push_back(b); qc.push_back(cin); qs.push_back(s); qm.push_back(m); end
                tick();
                n_cmp++; if (ds_mis !== (v && m)) begin n_bad++; $display("FAIL rnd_mismatch run %0d got %b want %b", run, ds_mis, v && m); end
            end
            vld = 1'b0;
            e4_err = 0; et_err = 0; es_err = 0; first = -1;
            for (int i = 0; i < 10; i++) if (qm[i]) begin
                if (i < 4) e4_err++;
                if (i < 7) et_err++;
                es_err++;
                if (first < 0 && i < 4) first = i;
            end
            n_cmp++; if (d4_vec !== 16'd4 || d4_err !== 16'(e4_err) || d4_pass !== (e4_err == 0)) begin n_bad++; $display("FAIL rnd_d4 run %0d vec=%0d err=%0d pass=%b want 4 %0d %b", run, d4_vec, d4_err, d4_pass, e4_err, e4_err == 0); end
            n_cmp++; if (dt_vec !== 3'd7 || dt_err !== 3'(et_err) || dt_done !== 1'b1) begin n_bad++; $display("FAIL rnd_dt run %0d vec=%0d err=%0d want 7 %0d", run, dt_vec, dt_err, et_err); end
            n_cmp++; if (ds_vec !== 4'd10 || ds_err !== 4'(es_err) || ds_busy !== 1'b1 || ds_done !== 1'b0) begin n_bad++; $display("FAIL rnd_ds run %0d vec=%0d err=%0d busy=%b want 10 %0d 1", run, ds_vec, ds_err, ds_busy, es_err); end
`ifdef ADDCHK_FIRST_FAIL_CAPTURE_EN
            if (first >= 0) begin
                n_cmp++; if ({d4_fa, d4_fb, d4_fcin, d4_fs} !== {qa[first], qb[first], qc[first], qs[first]}) begin n_bad++; $display("FAIL rnd_capture run %0d got %h want %h", run, {d4_fa, d4_fb, d4_fcin, d4_fs}, {qa[first], qb[first], qc[first], qs[first]}); end
            end else begin
                n_cmp++; if ({d4_fa, d4_fb, d4_fcin, d4_fs} !== 25'h0) begin n_bad++; $display("FAIL rnd_capture run %0d got %h want 0", run, {d4_fa, d4_fb, d4_fcin, d4_fs}); end
            end
`else
            n_cmp++; if ({d4_fa, d4_fb, d4_fcin, d4_fs} !== 25'h0) begin n_bad++; $display("FAIL rnd_capture run %0d got %h want 0 (first %0d)", run, {d4_fa, d4_fb, d4_fcin, d4_fs}, first); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_directed4();
        test_errors();
        test_gaps();
        test_reset_midrun();
        test_saturate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
